// File: rtl/mux_demux_router_if.sv
// rtl/mux_demux_router_if.sv - lane bus bundle between switch/button side and the router
//
// Purpose: groups the router's control, data and status signals.
//   master modport : the driving side (board inputs / bench)
//   slave modport  : the router itself
// Signals:
//   en, scan               routing enable, auto-scan mode select
//   in_bus                 CHANNELS lanes of WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   mux_sel, demux_sel     manual source / destination lane
//   out_bus                registered output lanes, same packing as in_bus
//   valid, sel_err         one-cycle pulses: lane written / out-of-range select dropped
//   active_src, active_dst lanes of the last completed write
//   lane_count             per-destination write counters (ROUTER_LANE_COUNT_EN only)
interface mux_demux_router_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      en;
  logic                      scan;
  logic [WIDTH*CHANNELS-1:0] in_bus;
  logic [SELW-1:0]           mux_sel;
  logic [SELW-1:0]           demux_sel;
  logic [WIDTH*CHANNELS-1:0] out_bus;
  logic                      valid;
  logic [SELW-1:0]           active_src;
  logic [SELW-1:0]           active_dst;
  logic                      sel_err;
`ifdef ROUTER_LANE_COUNT_EN
  logic [CHANNELS*8-1:0]     lane_count;
`endif

  modport master (
    output en, scan, in_bus, mux_sel, demux_sel,
    input  out_bus, valid, active_src, active_dst, sel_err
`ifdef ROUTER_LANE_COUNT_EN
    , input lane_count
`endif
  );

  modport slave (
    input  en, scan, in_bus, mux_sel, demux_sel,
    output out_bus, valid, active_src, active_dst, sel_err
`ifdef ROUTER_LANE_COUNT_EN
    , output lane_count
`endif
  );
endinterface

// File: rtl/mux_demux_router.sv
// rtl/mux_demux_router.sv - two-stage registered lane mux/demux with auto-scan
//
// Purpose: picks one of CHANNELS input lanes and writes it into one of CHANNELS
// registered output lanes. Stage 1 captures lane data and selects, stage 2
// updates the chosen output lane (others held when HOLD=1, cleared when HOLD=0).
// Selects come from mux_sel/demux_sel (scan=0) or from an internal scan index
// that advances every SCAN_DIV enabled cycles (scan=1).
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    mux_demux_router_if.slave (en, scan, in_bus, mux_sel, demux_sel in;
//          out_bus, valid, active_src, active_dst, sel_err out)
// Optional: ROUTER_LANE_COUNT_EN adds bus.lane_count, one saturating 8-bit
//           counter of completed writes per destination lane.
module mux_demux_router #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SCAN_DIV = 4,
  parameter int HOLD     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_demux_router_if.slave  bus
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SELW:0] CH_LIM = (SELW+1)'(CHANNELS);

  logic [SELW-1:0]           r_scan_idx;
  logic [DIVW-1:0]           r_div;
  logic                      r_s1_valid;
  logic [WIDTH-1:0]          r_s1_data;
  logic [SELW-1:0]           r_s1_src;
  logic [SELW-1:0]           r_s1_dst;
  logic                      r_sel_err;
  logic [WIDTH*CHANNELS-1:0] r_out;
  logic                      r_valid;
  logic [SELW-1:0]           r_act_src;
  logic [SELW-1:0]           r_act_dst;

  logic [SELW-1:0]           w_src;
  logic [SELW-1:0]           w_dst;
  logic                      w_in_range;
  logic [WIDTH-1:0]          w_lane;

  assign w_src      = bus.scan ? r_scan_idx : bus.mux_sel;
  assign w_dst      = bus.scan ? r_scan_idx : bus.demux_sel;
  // Zero-extended compare so non-power-of-two CHANNELS can flag unused codes.
  assign w_in_range = ({1'b0, w_src} < CH_LIM) && ({1'b0, w_dst} < CH_LIM);

  // Explicit decode keeps out-of-range selects from indexing past in_bus.
  always_comb begin
    w_lane = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_src == SELW'(k)) w_lane = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Scan sequencer: leaving scan mode parks it at lane 0; en=0 freezes it.
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.scan) begin
      r_div      <= '0;
      r_scan_idx <= '0;
    end else if (bus.en) begin
      if (r_div == DIVW'(SCAN_DIV - 1)) begin
        r_div      <= '0;
        r_scan_idx <= (r_scan_idx == SELW'(CHANNELS - 1)) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Stage 1: capture the selected lane and its routing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_src   <= '0;
      r_s1_dst   <= '0;
      r_sel_err  <= 1'b0;
    end else if (bus.en) begin
      r_s1_valid <= w_in_range;
      r_s1_data  <= w_lane;
      r_s1_src   <= w_src;
      r_s1_dst   <= w_dst;
      r_sel_err  <= !w_in_range;
    end else begin
      r_s1_valid <= 1'b0;
      r_sel_err  <= 1'b0;
    end
  end

  // Stage 2: write the destination lane; runs regardless of en so an
  // in-flight word still lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_act_src <= '0;
      r_act_dst <= '0;
    end else if (r_s1_valid) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (r_s1_dst == SELW'(k))  r_out[k*WIDTH +: WIDTH] <= r_s1_data;
        else if (HOLD == 0)        r_out[k*WIDTH +: WIDTH] <= '0;
      end
      r_valid   <= 1'b1;
      r_act_src <= r_s1_src;
      r_act_dst <= r_s1_dst;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_bus    = r_out;
  assign bus.valid      = r_valid;
  assign bus.active_src = r_act_src;
  assign bus.active_dst = r_act_dst;
  assign bus.sel_err    = r_sel_err;

`ifdef ROUTER_LANE_COUNT_EN
  logic [7:0] r_lane_cnt [CHANNELS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) r_lane_cnt[k] <= '0;
    end else if (r_s1_valid) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (r_s1_dst == SELW'(k) && r_lane_cnt[k] != 8'hFF)
          r_lane_cnt[k] <= r_lane_cnt[k] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    assign bus.lane_count[g*8 +: 8] = r_lane_cnt[g];
  end
`endif
endmodule

// File: tb/tb_mux_demux_router.sv
// tb/tb_mux_demux_router.sv - directed bench for mux_demux_router
module tb_mux_demux_router;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Main instance (HOLD=1, SCAN_DIV=2), clear-mode instance, 3-lane instance.
  mux_demux_router_if #(.WIDTH(4), .CHANNELS(4)) m_if ();
  mux_demux_router_if #(.WIDTH(4), .CHANNELS(4)) c_if ();
  mux_demux_router_if #(.WIDTH(4), .CHANNELS(3)) t_if ();

  mux_demux_router #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(2), .HOLD(1))
    u_main (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  mux_demux_router #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(4), .HOLD(0))
    u_clr  (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));
  mux_demux_router #(.WIDTH(4), .CHANNELS(3), .SCAN_DIV(4), .HOLD(1))
    u_ch3  (.clk(clk), .rst_n(rst_n), .bus(t_if.slave));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] in_val;
  logic [3:0]  scan_seq [9];

  initial begin
    scan_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0};
    in_val = 16'h6A59;
    rst_n = 1'b0;
    m_if.en = 1'b1; m_if.scan = 1'b0; m_if.in_bus = in_val;
    m_if.mux_sel = '0; m_if.demux_sel = '0;
    c_if.en = 1'b0; c_if.scan = 1'b0; c_if.in_bus = in_val;
    c_if.mux_sel = '0; c_if.demux_sel = '0;
    t_if.en = 1'b0; t_if.scan = 1'b0; t_if.in_bus = 12'h6A5;
    t_if.mux_sel = '0; t_if.demux_sel = '0;

    // Reset
    tick(2);
    check("rst_out",     32'(m_if.out_bus), 32'h0);
    check("rst_valid",   32'(m_if.valid),   32'h0);
    check("rst_selerr",  32'(m_if.sel_err), 32'h0);
    check("rst_actsrc",  32'(m_if.active_src), 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("rel1_out",    32'(m_if.out_bus), 32'h0);
    check("rel1_valid",  32'(m_if.valid),   32'h0);
    tick(1);
    check("rel2_out",    32'(m_if.out_bus), 32'h0009);
    check("rel2_valid",  32'(m_if.valid),   32'h1);

    // Manual sweep, source-major so the last four writes take lane 3 (=6)
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 4; d++) begin
        m_if.mux_sel = 2'(s); m_if.demux_sel = 2'(d);
        tick(2);
        check($sformatf("sweep_lane_s%0d_d%0d", s, d),
              32'((m_if.out_bus >> (d*4)) & 16'hF), 32'((in_val >> (s*4)) & 16'hF));
        check($sformatf("sweep_src_s%0d_d%0d", s, d), 32'(m_if.active_src), 32'(s));
        check($sformatf("sweep_dst_s%0d_d%0d", s, d), 32'(m_if.active_dst), 32'(d));
        tick(1);
      end
    end
    check("sweep_final", 32'(m_if.out_bus), 32'h6666);

    // HOLD=0: other lanes cleared on every write
    c_if.en = 1'b1; c_if.mux_sel = 2'd2; c_if.demux_sel = 2'd1;
    tick(2);
    check("clr_d1",      32'(c_if.out_bus), 32'h00A0);
    c_if.demux_sel = 2'd3;
    tick(1);
    check("clr_d3_lat1", 32'(c_if.out_bus), 32'h00A0);
    tick(1);
    check("clr_d3",      32'(c_if.out_bus), 32'hA000);

    // Enable gating: in-flight word completes, then everything holds
    m_if.mux_sel = 2'd0; m_if.demux_sel = 2'd0;
    tick(2);
    check("gate_route",  32'(m_if.out_bus), 32'h6669);
    m_if.en = 1'b0; m_if.in_bus = 16'hFFFF;
    tick(1);
    check("gate_flight_valid", 32'(m_if.valid),   32'h1);
    check("gate_flight_out",   32'(m_if.out_bus), 32'h6669);
    tick(1);
    check("gate_valid0", 32'(m_if.valid),   32'h0);
    tick(3);
    check("gate_hold",   32'(m_if.out_bus), 32'h6669);
    check("gate_valid",  32'(m_if.valid),   32'h0);
    check("gate_selerr", 32'(m_if.sel_err), 32'h0);

    // Auto-scan, two cycles per lane, wraps to lane 0
    m_if.in_bus = 16'h1234; m_if.scan = 1'b1; m_if.en = 1'b1;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      check($sformatf("scan_src_%0d", i), 32'(m_if.active_src), 32'(scan_seq[i]));
      check($sformatf("scan_dst_%0d", i), 32'(m_if.active_dst), 32'(scan_seq[i]));
      check($sformatf("scan_vld_%0d", i), 32'(m_if.valid),      32'h1);
    end
    check("scan_out",    32'(m_if.out_bus), 32'h1234);

    // Three lanes: select code 3 is dropped with a one-cycle error pulse
    t_if.en = 1'b1; t_if.mux_sel = 2'd1; t_if.demux_sel = 2'd2;
    tick(2);
    check("ch3_route",   32'(t_if.out_bus), 32'hA00);
    t_if.mux_sel = 2'd3;
    tick(1);
    check("ch3_err_on",  32'(t_if.sel_err), 32'h1);
    t_if.mux_sel = 2'd1;
    tick(1);
    check("ch3_err_off", 32'(t_if.sel_err), 32'h0);
    check("ch3_err_vld", 32'(t_if.valid),   32'h0);
    check("ch3_err_out", 32'(t_if.out_bus), 32'hA00);
    t_if.demux_sel = 2'd3;
    tick(1);
    check("ch3_derr_on", 32'(t_if.sel_err), 32'h1);
    t_if.demux_sel = 2'd0;
    tick(1);
    check("ch3_derr_vld", 32'(t_if.valid),   32'h0);
    check("ch3_derr_out", 32'(t_if.out_bus), 32'hA00);
    tick(1);
    check("ch3_recover",  32'(t_if.out_bus), 32'hA0A);

`ifdef ROUTER_LANE_COUNT_EN
    c_if.mux_sel = 2'd0; c_if.demux_sel = 2'd0;
    tick(302);
    check("cnt_sat_l0",  32'(c_if.lane_count[7:0]), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
